// File: rtl/i2c_pkg.sv
// i2c_pkg: shared byte width, byte type and default FIFO depth for the I2C RX/TX paths
package i2c_pkg;
  localparam int I2C_BYTE_W = 8;
  localparam int I2C_FIFO_DEPTH = 16;
  typedef logic [I2C_BYTE_W-1:0] i2c_byte_t;
endpackage

// File: rtl/i2c_fifo_mem.sv
// i2c_fifo_mem: DEPTH x byte register array, one synchronous write port, one async read port
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o combinational read of the head entry.
// Contents are deliberately not reset.
module i2c_fifo_mem import i2c_pkg::*; #(
  parameter int DEPTH = I2C_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  i2c_byte_t                wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output i2c_byte_t                rdata_o
);
  i2c_byte_t mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/i2c_rx_buffer.sv
// i2c_rx_buffer: FWFT byte FIFO capturing one byte per rising edge of the slave's data_valid
// Ports: clk, reset (sync, active-low); rx_data/rx_valid from the slave;
//   rd_data/rd_valid/rd_ready host read port (pop on rd_valid & rd_ready);
//   level/full fill status; overflow sticky drop flag cleared by ovf_clr;
//   almost_full (level >= AF_THRESH) present only when I2C_RX_ALMOST_FULL_EN is defined.
module i2c_rx_buffer import i2c_pkg::*; #(
  parameter int DEPTH = I2C_FIFO_DEPTH
`ifdef I2C_RX_ALMOST_FULL_EN
  , parameter int AF_THRESH = 12
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  i2c_byte_t                  rx_data,
  input  logic                       rx_valid,
  output i2c_byte_t                  rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overflow,
`ifdef I2C_RX_ALMOST_FULL_EN
  output logic                       almost_full,
`endif
  input  logic                       ovf_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          rx_valid_q, overflow_q, overflow_d;
  logic          push, pop, wr_en, drop;
  i2c_byte_t     head;
  i2c_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );
  assign rd_valid = level_q != '0;
  assign full     = level_q == LW'(DEPTH);
  assign rd_data  = rd_valid ? head : '0;
  assign level    = level_q;
  assign overflow = overflow_q;
  always_comb begin
    push       = rx_valid & ~rx_valid_q;
    pop        = rd_valid & rd_ready;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    wr_en      = push & (~full | pop);
    drop       = push & full & ~pop;
    wr_ptr_d   = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(wr_en) - LW'(pop);
    overflow_d = drop | (overflow_q & ~ovf_clr);
  end
  always_ff @(posedge clk) begin
    // edge detector follows rx_valid even in reset so a held level never pushes on release
    rx_valid_q <= rx_valid;
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end
`ifdef I2C_RX_ALMOST_FULL_EN
  logic almost_full_q;
  always_ff @(posedge clk)
    almost_full_q <= reset ? (level_d >= LW'(AF_THRESH)) : 1'b0;
  assign almost_full = almost_full_q;
`endif
endmodule
